// File: rtl/prog_mem_responder_pkg.sv
// Shared types for the program-memory responder: FSM states and default geometry.
package prog_mem_responder_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } resp_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 5;

  // The IO port sits at the top word of the address space by default.
  function automatic int unsigned io_addr_default(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

  function automatic logic is_cpu_phase(input resp_state_t s);
    return (s == S_RUN) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/prog_mem_responder_mem_array.sv
// Single-write-port storage with a registered, read-first read port.
module prog_mem_responder_mem_array
  import prog_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents survive reset so a partially loaded program is not lost.
  always_ff @(posedge clk_) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_ or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_responder.sv
// Program memory responder: byte loader, CPU bus server, IO port and halt tracking.
// Optional build macro LOAD_CHECKSUM_EN treats the ld_last byte as a checksum.
module prog_mem_responder
  import prog_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned IO_ADDR    = io_addr_default(ADDR_WIDTH)
) (
  input  logic                  clk_,
  input  logic                  rst_n,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  halt,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  restart,
  output logic                  cpu_rst_n,
  output logic [DATA_WIDTH-1:0] io_out,
  output logic                  io_strobe,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IO_A   = ADDR_WIDTH'(IO_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH - 1);

  resp_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic [DATA_WIDTH-1:0] io_out_q, io_out_d;
  logic                  io_strobe_q, io_strobe_d;

  logic                  cpu_phase, ld_accept, ld_final;
  logic                  mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef LOAD_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, sum_next;
`endif

  always_comb begin
    cpu_phase = is_cpu_phase(state_q);
    ld_accept = (state_q == S_LOAD) && ld_valid;
    ld_final  = ld_accept && (ld_last || (ld_addr_q == LAST_A));
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
`ifdef LOAD_CHECKSUM_EN
    sum_d     = sum_q;
    sum_next  = sum_q + 8'(ld_data);
`endif

    case (state_q)
      S_LOAD: begin
        mem_waddr = ld_addr_q;
        mem_wdata = ld_data;
        mem_we    = ld_accept;
        // The address stops on the final byte so the counter never wraps.
        if (ld_accept && !ld_final) begin
          ld_addr_d = ld_addr_q + ADDR_WIDTH'(1);
        end
        if (ld_final) begin
          state_d = S_RUN;
        end
`ifdef LOAD_CHECKSUM_EN
        if (ld_accept) begin
          sum_d = sum_next;
        end
        if (ld_accept && ld_last) begin
          mem_we  = 1'b0;
          state_d = (sum_next == 8'd0) ? S_RUN : S_ERR;
        end
`endif
      end
      S_RUN: begin
        mem_we = mem_wr;
        if (halt) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        mem_we = mem_wr;
        if (restart) begin
          state_d   = S_LOAD;
          ld_addr_d = '0;
`ifdef LOAD_CHECKSUM_EN
          sum_d     = 8'd0;
`endif
        end
      end
`ifdef LOAD_CHECKSUM_EN
      S_ERR: begin
        if (restart) begin
          state_d   = S_LOAD;
          ld_addr_d = '0;
          sum_d     = 8'd0;
        end
      end
`endif
      default: begin
        state_d = S_LOAD;
      end
    endcase

    mem_re      = cpu_phase && mem_rd;
    // CPU runs only while both this cycle and the next are CPU phases.
    cpu_rst_n_d = cpu_phase && is_cpu_phase(state_d);
    io_strobe_d = cpu_phase && mem_wr && (addr == IO_A);
    io_out_d    = io_strobe_d ? data_in : io_out_q;
  end

  always_ff @(posedge clk_ or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      ld_addr_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      io_out_q    <= '0;
      io_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_addr_q   <= ld_addr_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge clk_ or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'd0;
    end else begin
      sum_q <= sum_d;
    end
  end
  assign err = (state_q == S_ERR);
`else
  assign err = 1'b0;
`endif

  prog_mem_responder_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_array (
    .clk_    (clk_),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (addr),
    .rdata_o (data_out)
  );

  assign ld_ready  = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);
  assign cpu_rst_n = cpu_rst_n_q;
  assign io_out    = io_out_q;
  assign io_strobe = io_strobe_q;

endmodule
